// File: rtl/seg_display_scheduler.sv
// Four-digit seven-segment display scheduler: picks one of four 13-bit sources,
// converts it to BCD with a serial double-dabble engine and scans the digits.
module seg_display_scheduler #(
  parameter int unsigned REFRESH_BITS = 20,
  parameter int unsigned ROTATE_BITS  = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] src0,
  input  logic [12:0] src1,
  input  logic [12:0] src2,
  input  logic [12:0] src3,
  input  logic [1:0]  sel,
  input  logic        auto_rotate,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [1:0]  src_idx,
  output logic [15:0] bcd,
  output logic        busy,
  output logic [3:0]  Anode,
  output logic [6:0]  LED_out
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

  localparam logic [3:0] LastIter = 4'd12;

  state_e                  state_q, state_d;
  logic [12:0]             bin_q, bin_d;
  logic [15:0]             scratch_q, scratch_d;
  logic [3:0]              iter_q, iter_d;
  logic [15:0]             bcd_q, bcd_d;
  logic [1:0]              src_idx_q;
  logic [ROTATE_BITS-1:0]  rotate_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [3:0]              anode_q, anode_d;
  logic [6:0]              led_q, led_d;
  logic [12:0]             src_mux;
  logic [15:0]             scratch_adj;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Source ownership: manual select, or advance one source per rotate-counter wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_idx_q <= 2'd0;
      rotate_q  <= '0;
    end else if (!auto_rotate) begin
      src_idx_q <= sel;
      rotate_q  <= '0;
    end else begin
      rotate_q <= rotate_q + ROTATE_BITS'(1);
      if (&rotate_q) begin
        src_idx_q <= src_idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    src_mux = src0;
    unique case (src_idx_q)
      2'd0: src_mux = src0;
      2'd1: src_mux = src1;
      2'd2: src_mux = src2;
      2'd3: src_mux = src3;
      default: src_mux = src0;
    endcase
  end

  assign scratch_adj = dabble_adjust(scratch_q);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (!freeze) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        bin_d     = src_mux;
        scratch_d = '0;
        iter_d    = '0;
        state_d   = StShift;
      end
      StShift: begin
        {scratch_d, bin_d} = {scratch_adj[14:0], bin_q, 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == LastIter) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        bcd_d   = scratch_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
    end
  end

  // Digit scan: the top two refresh bits pick the digit; blanking uses committed bcd only.
  logic [1:0] digit_sel;
  logic       blank_th, blank_hu, blank_te;
  logic [3:0] nibble;
  logic       blank_cur;

  assign digit_sel = refresh_q[REFRESH_BITS-1 -: 2];
  assign blank_th  = blank_lz && (bcd_q[15:12] == 4'd0);
  assign blank_hu  = blank_th && (bcd_q[11:8] == 4'd0);
  assign blank_te  = blank_hu && (bcd_q[7:4] == 4'd0);

  always_comb begin
    nibble    = bcd_q[3:0];
    blank_cur = 1'b0;
    anode_d   = 4'b1110;
    unique case (digit_sel)
      2'd0: begin
        nibble    = bcd_q[15:12];
        blank_cur = blank_th;
        anode_d   = 4'b0111;
      end
      2'd1: begin
        nibble    = bcd_q[11:8];
        blank_cur = blank_hu;
        anode_d   = 4'b1011;
      end
      2'd2: begin
        nibble    = bcd_q[7:4];
        blank_cur = blank_te;
        anode_d   = 4'b1101;
      end
      2'd3: begin
        nibble    = bcd_q[3:0];
        blank_cur = 1'b0;
        anode_d   = 4'b1110;
      end
      default: begin
        nibble    = bcd_q[3:0];
        blank_cur = 1'b0;
        anode_d   = 4'b1110;
      end
    endcase
    led_d = seg_encode(nibble);
    if (blank_cur) begin
      anode_d = 4'b1111;
      led_d   = 7'b1111111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      anode_q   <= 4'b1111;
      led_q     <= 7'b1111111;
    end else begin
      refresh_q <= refresh_q + REFRESH_BITS'(1);
      anode_q   <= anode_d;
      led_q     <= led_d;
    end
  end

  assign src_idx = src_idx_q;
  assign bcd     = bcd_q;
  assign busy    = (state_q != StIdle);
  assign Anode   = anode_q;
  assign LED_out = led_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler: cycle-level reference model plus
// directed scenarios with literal expectations.
module tb_seg_display_scheduler;

  localparam int unsigned RefBits = 4;
  localparam int unsigned RotBits = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] src0 = '0, src1 = '0, src2 = '0, src3 = '0;
  logic [1:0]  sel = '0;
  logic        auto_rotate = 1'b0, freeze = 1'b0, blank_lz = 1'b0;
  logic [1:0]  src_idx;
  logic [15:0] bcd;
  logic        busy;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;

  int checks = 0;
  int failures = 0;

  seg_display_scheduler #(
    .REFRESH_BITS(RefBits),
    .ROTATE_BITS (RotBits)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src0       (src0),
    .src1       (src1),
    .src2       (src2),
    .src3       (src3),
    .sel        (sel),
    .auto_rotate(auto_rotate),
    .freeze     (freeze),
    .blank_lz   (blank_lz),
    .src_idx    (src_idx),
    .bcd        (bcd),
    .busy       (busy),
    .Anode      (Anode),
    .LED_out    (LED_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int digit);
    logic [6:0] tbl [10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return tbl[digit];
  endfunction

  function automatic bit is_blank(input int d, input int v, input logic bl);
    return bl && ((d == 0 && v < 1000) || (d == 1 && v < 100) || (d == 2 && v < 10));
  endfunction

  function automatic logic [3:0] exp_anode(input int d, input int v, input logic bl);
    if (is_blank(d, v, bl)) return 4'b1111;
    return ~(4'b1000 >> d);
  endfunction

  function automatic logic [6:0] exp_led(input int d, input int v, input logic bl);
    int p;
    if (is_blank(d, v, bl)) return 7'b1111111;
    p = (d == 0) ? 1000 : (d == 1) ? 100 : (d == 2) ? 10 : 1;
    return seg_of(v / p % 10);
  endfunction

  // Phase of the 16-cycle conversion: 0 idle, 1 load, 2..14 shifting, 15 commit.
  int          m_phase, m_latched, m_val, m_ref, m_rot;
  logic [1:0]  m_idx;
  logic [3:0]  m_anode;
  logic [6:0]  m_led;
  logic [12:0] srcs [4];

  assign srcs[0] = src0;
  assign srcs[1] = src1;
  assign srcs[2] = src2;
  assign srcs[3] = src3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_latched <= 0; m_val <= 0; m_ref <= 0; m_rot <= 0;
      m_idx <= 2'd0; m_anode <= 4'b1111; m_led <= 7'b1111111;
    end else begin
      if (m_phase == 0) m_phase <= freeze ? 0 : 1;
      else if (m_phase == 1) begin
        m_latched <= int'(srcs[m_idx]);
        m_phase   <= 2;
      end else if (m_phase < 15) m_phase <= m_phase + 1;
      else begin
        m_val   <= m_latched;
        m_phase <= 0;
      end
      if (!auto_rotate) begin
        m_idx <= sel;
        m_rot <= 0;
      end else begin
        m_rot <= (m_rot + 1) % (1 << RotBits);
        if (m_rot == (1 << RotBits) - 1) m_idx <= m_idx + 2'd1;
      end
      m_anode <= exp_anode(m_ref / (1 << (RefBits - 2)), m_val, blank_lz);
      m_led   <= exp_led(m_ref / (1 << (RefBits - 2)), m_val, blank_lz);
      m_ref   <= (m_ref + 1) % (1 << RefBits);
    end
  end

  always @(negedge clk) begin
    check("src_idx", 32'(src_idx), 32'(m_idx));
    check("bcd", 32'(bcd), 32'(to_bcd(m_val)));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("Anode", 32'(Anode), 32'(m_anode));
    check("LED_out", 32'(LED_out), 32'(m_led));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  logic [6:0] seen_led [4];
  int lit_cnt, units_cnt, units_ok;

  initial begin
    #1 rst = 1'b1;
    src0 = 13'd1234;
    @(posedge clk); #1 rst = 1'b0;
    check("reset_bcd_before_commit", 32'(bcd), 32'h0);
    tick(16);
    check("first_commit_1234", 32'(bcd), 32'h1234);
    check("idle_after_commit", 32'(busy), 32'd0);

    // Max value and scan order
    src2 = 13'd8191; sel = 2'd2;
    tick(40);
    check("max_8191", 32'(bcd), 32'h8191);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      for (int d = 0; d < 4; d++) if (Anode == ~(4'b1000 >> d)) seen_led[d] = LED_out;
    end
    check("scan_thousands", 32'(seen_led[0]), 32'b0000000);
    check("scan_hundreds", 32'(seen_led[1]), 32'b1001111);
    check("scan_tens", 32'(seen_led[2]), 32'b0000100);
    check("scan_units", 32'(seen_led[3]), 32'b1001111);

    // Leading-zero blanking
    sel = 2'd0; src0 = 13'd7; blank_lz = 1'b1;
    tick(40);
    lit_cnt = 0; units_ok = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (Anode != 4'b1111) lit_cnt++;
      if (Anode == 4'b1110 && LED_out == 7'b0001111) units_ok++;
    end
    check("blank_lit_cycles", 32'(lit_cnt), 32'd4);
    check("blank_units_7", 32'(units_ok), 32'd4);
    src0 = 13'd0;
    tick(40);
    units_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (Anode == 4'b1110 && LED_out == 7'b0000001) units_cnt++;
    end
    check("zero_units_shown", 32'(units_cnt), 32'd4);
    blank_lz = 1'b0;
    tick(20);
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (Anode != 4'b1111) lit_cnt++;
    end
    check("no_blank_all_lit", 32'(lit_cnt), 32'd16);

    // Freeze coherence
    sel = 2'd1; src1 = 13'd42;
    tick(40);
    check("freeze_pre_42", 32'(bcd), 32'h0042);
    wait_busy("freeze_wait_busy");
    tick(3);
    freeze = 1'b1; src1 = 13'd999;
    tick(40);
    check("freeze_hold_42", 32'(bcd), 32'h0042);
    check("freeze_parked", 32'(busy), 32'd0);
    freeze = 1'b0;
    tick(16);
    check("unfreeze_999", 32'(bcd), 32'h0999);

    // Auto-rotate including 3 -> 0 wrap
    src0 = 13'd1; src1 = 13'd22; src2 = 13'd333; src3 = 13'd4444;
    sel = 2'd0;
    tick(2);
    auto_rotate = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(64);
      check("rotate_idx", 32'(src_idx), 32'(k % 4));
    end
    tick(40);
    auto_rotate = 1'b0;
    tick(2);
    check("rotate_off_takes_sel", 32'(src_idx), 32'd0);

    // Async reset mid-conversion
    src0 = 13'd1234;
    wait_busy("reset_wait_busy");
    tick(5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bcd", 32'(bcd), 32'h0);
    check("async_rst_anode", 32'(Anode), 32'hf);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_led", 32'(LED_out), 32'h7f);
    @(posedge clk); #1 rst = 1'b0;
    tick(16);
    check("after_rst_1234", 32'(bcd), 32'h1234);

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Sequences the four-digit seven-segment display for the CPU board.
- Shares the display between four 13-bit requesters, such as PC, ALU result, register readback and cycle count. The source is chosen manually or by timed auto-rotation.
- Converts the chosen value to BCD with a multi-cycle shift-add-3 (double-dabble) engine.
- Time-multiplexes the four digits onto the active-low anode and segment pins.

Parameters:
- REFRESH_BITS, 20, width of the digit-scan counter; the top 2 bits select the digit.
- ROTATE_BITS, 27, width of the auto-rotate counter; the source advances when this counter wraps.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- src0  input  13  requester 0 value
- src1  input  13  requester 1 value
- src2  input  13  requester 2 value
- src3  input  13  requester 3 value
- sel  input  2  manual source select, used when auto_rotate=0
- auto_rotate  input  1  1 = rotate sources on a timer
- freeze  input  1  1 = hold the displayed digits and suspend new conversions
- blank_lz  input  1  1 = blank leading zero digits; the units digit is never blanked
- src_idx  output  2  source currently owning the display
- bcd  output  16  committed digits {thousands, hundreds, tens, units}
- busy  output  1  high while the conversion FSM is not IDLE
- Anode  output  4  digit enables, active-low; bit 3 = leftmost (thousands)
- LED_out  output  7  segments abcdefg, active-low

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - All counters 0.
  - src_idx=0, bcd=16'h0000, busy=0.
  - Anode=4'b1111, LED_out=7'b1111111.
- Source selection:
  - auto_rotate=0: src_idx <= sel every cycle; 1-cycle latency.
  - auto_rotate=1: rotate counter increments every cycle. When it wraps to 0, src_idx <= src_idx+1 (mod 4; 3 wraps to 0).
  - auto_rotate=0 holds the rotate counter at 0.
  - Switching auto_rotate from 1 to 0 takes sel on the next cycle.
- Conversion FSM:
  - IDLE: if freeze=0, go to LOAD next cycle; otherwise stay.
  - LOAD (1 cycle):
    - Capture bin <= mux(src_idx) into the shift register.
    - Clear the 16-bit scratch BCD.
    - Set iteration count to 0.
  - SHIFT (13 cycles):
    - Each cycle, add 3 to every scratch nibble that is ≥5.
    - Then shift {scratch, bin} left by 1.
    - Increment the count; leave SHIFT when count reaches 13.
  - COMMIT (1 cycle): bcd <= scratch; return to IDLE.
- Conversion period and coherence:
  - Period is 16 cycles: IDLE, LOAD, 13×SHIFT, COMMIT.
  - The value sampled at LOAD appears on bcd at most 15 cycles later.
  - bcd changes only in COMMIT, so partial results are never visible.
- Value range: 13 bits gives a maximum of 8191 ≤ 9999, so no overflow handling is needed.
- Source changes mid-conversion have no effect until the next LOAD.
- freeze asserted mid-conversion:
  - The in-flight conversion completes and commits.
  - The FSM then parks in IDLE with bcd held.
- busy = (state != IDLE).
- Scan:
  - refresh counter increments every cycle and wraps freely.
  - d = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - Digit mapping:
    - d=0: thousands, Anode 0111
    - d=1: hundreds, Anode 1011
    - d=2: tens, Anode 1101
    - d=3: units, Anode 1110
  - Anode and LED_out are registered one cycle after d.
- Leading-zero blanking, with blank_lz=1:
  - Blank thousands if it is 0.
  - Blank hundreds if thousands and hundreds are both 0.
  - Blank tens if thousands, hundreds and tens are all 0.
  - A blanked digit drives Anode=4'b1111 and LED_out=7'b1111111.
- Segment encoding, abcdefg, active-low:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
  - 10–15 = 1111111 (unreachable)
- Reset mid-operation aborts the conversion immediately and restores all reset values. The first committed bcd appears at most 16 cycles after rst falls, when freeze=0.

Test Plan:
- Reset then convert: rst pulse; sel=0, src0=1234, freeze=0 → bcd=16'h1234 within 16 cycles of rst release; busy toggles with period 16.
- Max value and scan: src2=8191, sel=2, REFRESH_BITS=4 → bcd=16'h8191.
  - Over one 16-cycle scan, (Anode, LED_out) go (0111, 0000000), (1011, 1001111), (1101, 0000100), (1110, 1001111), each 1 cycle after d changes.
- Leading-zero blanking: src0=7, blank_lz=1 → Anode 1111 during d=0,1,2; Anode 1110 with LED_out=0001111 at d=3.
  - src0=0 → units shows 0000001.
  - blank_lz=0 → all four anodes lit.
- Freeze coherence: src1=42 committed; assert freeze mid-SHIFT with src1 changed to 999 → bcd stays 16'h0042 until freeze=0, then becomes 16'h0999 within 16 cycles.
- Auto-rotate: ROTATE_BITS=6, src0..3 = 1, 22, 333, 4444 → src_idx steps 0→1→2→3→0 every 64 cycles. bcd follows with ≤16 cycles lag; a 3→0 wrap is included.
- Async reset mid-conversion: assert rst in the 5th SHIFT cycle with no clock edge → bcd=0, Anode=1111 and busy=0 immediately; normal conversion resumes after release.
